fsa_overlay_stream_v3: RTL
==========================

FSA_OVERLAY_STREAM_V3 -- requirements
Module: fsa_overlay_stream_v3

Interface
REQ-001 Parameter C_CHANNEL_WIDTH, default 8: bits per colour channel.
REQ-002 Parameter C_S_CHANNEL, default 1: input channels; legal values are 1 (gray) or 3 (RGB).
REQ-003 Parameter C_IMG_WW, default 12: width of x coordinates.
REQ-004 Parameter C_IMG_HW, default 12: width of y coordinates.
REQ-005 Parameter C_REGIONS, default 4: number of overlay rectangles; legal range is 1..8.
REQ-006 Parameter C_FIFO_AW, default 4: output FIFO depth is 2^C_FIFO_AW; minimum value is 3.
REQ-007 Port clk, input, 1 bit: clock; reset is resetn, synchronous, active-low.
REQ-008 Port resetn, input, 1 bit: synchronous active-low reset.
REQ-009 Port mode, input, 2 bits: 0 = pass, 1 = fill, 2 = blend, 3 = invert.
REQ-010 Port region_en, input, C_REGIONS bits: per-region enable.
REQ-011 Ports region_x0 and region_x1, input, C_REGIONS*C_IMG_WW bits each: inclusive x bounds, packed with region i at slice i.
REQ-012 Ports region_y0 and region_y1, input, C_REGIONS*C_IMG_HW bits each: inclusive y bounds, packed the same way.
REQ-013 Port region_color, input, C_REGIONS*3*C_CHANNEL_WIDTH bits: per-region RGB colour.
REQ-014 Port group s_axis_tvalid/tready/tuser/tlast (1 bit each) and s_axis_tdata (C_CHANNEL_WIDTH*C_S_CHANNEL bits): input stream; tready is an output.
REQ-015 Port s_axis_source_x (C_IMG_WW bits) and s_axis_source_y (C_IMG_HW bits), input: coordinates of the current beat.
REQ-016 Port group m_axis_tvalid/tuser/tlast (1 bit each) and m_axis_tdata (3*C_CHANNEL_WIDTH bits), outputs, plus m_axis_tready input: output stream.
REQ-017 Port region_hit, output, C_REGIONS bits: sticky per-frame hit flags.

Function
REQ-018 A beat is accepted when s_axis_tvalid and s_axis_tready are both high; s_axis_tdata has no meaning otherwise.
REQ-019 Configuration (mode and all region_* ports) SHALL be copied into shadow registers on any accepted beat with tuser=1, and that beat SHALL use the new configuration.
REQ-020 Between tuser beats, input changes to mode or region_* SHALL have no effect.
REQ-021 Pipeline is fixed at 3 stages: S1 registers beat, coordinates and valid; S2 computes per-region hits; S3 selects the region and computes the output pixel.
REQ-022 An accepted beat SHALL be written into the FIFO exactly 3 cycles after acceptance.
REQ-023 Pipeline stages SHALL never stall; every accepted beat SHALL reach the FIFO.
REQ-024 Region hit condition: en[i] AND x0<=x<=x1 AND y0<=y<=y1, using unsigned inclusive compares.
REQ-025 A region with x0>x1 or y0>y1 SHALL never hit.
REQ-026 When several regions hit, the lowest index wins.
REQ-027 Base pixel: when C_S_CHANNEL=1 the gray value is replicated to all 3 channels; when C_S_CHANNEL=3 it passes unchanged.
REQ-028 With no region hit, or mode=0, the output SHALL equal the base pixel.
REQ-029 Mode 1 (fill): output = colour of the winning region.
REQ-030 Mode 2 (blend): each channel = (base + colour) >> 1, summed at C_CHANNEL_WIDTH+1 bits, truncated, no rounding.
REQ-031 Mode 3 (invert): output = bitwise NOT of the base pixel.
REQ-032 tuser and tlast SHALL travel with their beat unchanged.
REQ-033 s_axis_tready = NOT almost_full, where almost_full = (FIFO count >= 2^C_FIFO_AW - 4); this covers the 3 in-flight beats, so the FIFO never overflows.
REQ-034 On simultaneous FIFO write and read when full minus 1, count SHALL stay unchanged; a write into a full FIFO is a design error and the bench SHALL assert it never occurs.
REQ-035 Output register: it SHALL load from the FIFO when (!m_axis_tvalid OR m_axis_tready) AND FIFO is not empty.
REQ-036 m_axis_tvalid and m_axis_tdata SHALL stay stable while tvalid=1 and tready=0.
REQ-037 Minimum latency from acceptance to m_axis_tvalid is 4 cycles, given an empty FIFO and tready=1.
REQ-038 Full throughput of 1 beat per cycle SHALL be sustained while m_axis_tready=1.
REQ-039 region_hit[i] SHALL be set when region i wins in S3.
REQ-040 region_hit SHALL clear when a tuser beat enters S3; that beat's own hit is then set.

Reset
REQ-041 resetn low at a clock edge SHALL clear the pipeline valids, FIFO pointers and count, and the shadow configuration (mode=0, all regions disabled).
REQ-042 During reset: m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, region_hit=0, s_axis_tready=1.
REQ-043 Reset mid-frame SHALL discard all in-flight and buffered beats without producing partial output.
REQ-044 After reset, output SHALL be pass-through until the first tuser beat.

Verification
REQ-045 Gray pass-through: C_S_CHANNEL=1, mode=0, pixel 0x5A -> m_axis_tdata=0x5A5A5A, first valid 4 cycles after acceptance.
REQ-046 Priority and fill: region0 (2..4, 2..4) colour 0xFF0000, region1 (3..9, 3..9) colour 0x00FF00, mode=1 -> pixel (3,3) = 0xFF0000, (5,5) = 0x00FF00, (1,1) = base pixel.
REQ-047 Blend: mode=2, base RGB 0x204060, colour 0xFFFFFF -> 0x8F9FAF.
REQ-048 Backpressure: C_FIFO_AW=3, m_axis_tready=0 with continuous input -> s_axis_tready falls after 4 FIFO entries, exactly 8 beats stored, no loss or duplication after release, order preserved.
REQ-049 Config shadowing: change mode from 1 to 0 mid-frame -> no effect until the next tuser beat; region_hit clears at that beat's S3.
REQ-050 Reset with the FIFO holding 5 beats -> m_axis_tvalid=0 on the next cycle and no stale beat emitted afterwards.

Source files
------------

// File: rtl/fsa_overlay_stream_v3.sv
// Rectangle overlay on a pixel stream: 3-stage non-stalling pipeline, output FIFO, registered output.
// Configuration is shadowed on tuser beats so a frame always renders with one consistent setup.
module fsa_overlay_stream_v3 #(
    parameter int C_CHANNEL_WIDTH = 8,
    parameter int C_S_CHANNEL     = 1,
    parameter int C_IMG_WW        = 12,
    parameter int C_IMG_HW        = 12,
    parameter int C_REGIONS       = 4,
    parameter int C_FIFO_AW       = 4
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [1:0]                             mode,
    input  logic [C_REGIONS-1:0]                   region_en,
    input  logic [C_REGIONS*C_IMG_WW-1:0]          region_x0,
    input  logic [C_REGIONS*C_IMG_WW-1:0]          region_x1,
    input  logic [C_REGIONS*C_IMG_HW-1:0]          region_y0,
    input  logic [C_REGIONS*C_IMG_HW-1:0]          region_y1,
    input  logic [C_REGIONS*3*C_CHANNEL_WIDTH-1:0] region_color,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tuser,
    input  logic                                   s_axis_tlast,
    input  logic [C_CHANNEL_WIDTH*C_S_CHANNEL-1:0] s_axis_tdata,
    input  logic [C_IMG_WW-1:0]                    s_axis_source_x,
    input  logic [C_IMG_HW-1:0]                    s_axis_source_y,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tuser,
    output logic                                   m_axis_tlast,
    output logic [3*C_CHANNEL_WIDTH-1:0]           m_axis_tdata,
    output logic [C_REGIONS-1:0]                   region_hit
);

    localparam int CW    = C_CHANNEL_WIDTH;
    localparam int PW    = 3 * CW;
    localparam int EW    = PW + 2;
    localparam int DEPTH = 1 << C_FIFO_AW;
    localparam logic [C_FIFO_AW:0] AF_LEVEL = (C_FIFO_AW+1)'(DEPTH - 4);

    logic [1:0]                    sh_mode;
    logic [C_REGIONS-1:0]          sh_en;
    logic [C_REGIONS*C_IMG_WW-1:0] sh_x0, sh_x1;
    logic [C_REGIONS*C_IMG_HW-1:0] sh_y0, sh_y1;
    logic [C_REGIONS*PW-1:0]       sh_color;
    logic [1:0]                    sh2_mode;
    logic [C_REGIONS*PW-1:0]       sh2_color;

    logic                 accept;
    logic [PW-1:0]        in_base;
    logic                 s1_valid, s1_tuser, s1_tlast;
    logic [PW-1:0]        s1_data;
    logic [C_IMG_WW-1:0]  s1_x;
    logic [C_IMG_HW-1:0]  s1_y;
    logic                 s2_valid, s2_tuser, s2_tlast;
    logic [PW-1:0]        s2_data;
    logic [C_REGIONS-1:0] s2_hit;
    logic                 s3_valid, s3_tuser, s3_tlast;
    logic [PW-1:0]        s3_data;

    logic [C_REGIONS-1:0] hit;
    logic [C_REGIONS-1:0] win_onehot;
    logic [PW-1:0]        win_color;
    logic [PW-1:0]        pix;
    logic [CW-1:0]        ch_b, ch_k;

    logic [EW-1:0]        mem [DEPTH];
    logic [C_FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [C_FIFO_AW:0]   fifo_count;
    logic                 fifo_rd;
    logic                 almost_full;

    assign accept = s_axis_tvalid && s_axis_tready;

    generate
        if (C_S_CHANNEL == 1) begin : g_gray
            assign in_base = {3{s_axis_tdata}};
        end else begin : g_rgb
            assign in_base = s_axis_tdata;
        end
    endgenerate

    always_comb begin
        hit = '0;
        for (int i = 0; i < C_REGIONS; i++) begin
            hit[i] = sh_en[i]
                && (s1_x >= sh_x0[i*C_IMG_WW +: C_IMG_WW]) && (s1_x <= sh_x1[i*C_IMG_WW +: C_IMG_WW])
                && (s1_y >= sh_y0[i*C_IMG_HW +: C_IMG_HW]) && (s1_y <= sh_y1[i*C_IMG_HW +: C_IMG_HW]);
        end
    end

    // Lowest index wins; blend uses floor((b+k)/2) = b/2 + k/2 + (b0 & k0) to stay at channel width.
    always_comb begin
        win_onehot = s2_hit & (~s2_hit + C_REGIONS'(1));
        win_color  = '0;
        pix        = s2_data;
        ch_b       = '0;
        ch_k       = '0;
        for (int i = C_REGIONS - 1; i >= 0; i--) begin
            if (s2_hit[i]) win_color = sh2_color[i*PW +: PW];
        end
        if (s2_hit != '0) begin
            case (sh2_mode)
                2'd1: pix = win_color;
                2'd2: begin
                    for (int c = 0; c < 3; c++) begin
                        ch_b = s2_data[c*CW +: CW];
                        ch_k = win_color[c*CW +: CW];
                        pix[c*CW +: CW] = (ch_b >> 1) + (ch_k >> 1) + {{(CW-1){1'b0}}, ch_b[0] & ch_k[0]};
                    end
                end
                2'd3: pix = ~s2_data;
                default: pix = s2_data;
            endcase
        end
    end

    // Region bounds are consumed S1->S2, mode/colour S2->S3; the second shadow follows the tuser beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_mode    <= '0;
            sh_en      <= '0;
            sh_x0      <= '0;
            sh_x1      <= '0;
            sh_y0      <= '0;
            sh_y1      <= '0;
            sh_color   <= '0;
            sh2_mode   <= '0;
            sh2_color  <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            region_hit <= '0;
        end else begin
            if (accept && s_axis_tuser) begin
                sh_mode  <= mode;
                sh_en    <= region_en;
                sh_x0    <= region_x0;
                sh_x1    <= region_x1;
                sh_y0    <= region_y0;
                sh_y1    <= region_y1;
                sh_color <= region_color;
            end
            if (s1_valid && s1_tuser) begin
                sh2_mode  <= sh_mode;
                sh2_color <= sh_color;
            end
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (s2_valid) region_hit <= (s2_tuser ? '0 : region_hit) | win_onehot;
        end
    end

    always_ff @(posedge clk) begin
        s1_data  <= in_base;
        s1_x     <= s_axis_source_x;
        s1_y     <= s_axis_source_y;
        s1_tuser <= s_axis_tuser;
        s1_tlast <= s_axis_tlast;
        s2_data  <= s1_data;
        s2_hit   <= hit;
        s2_tuser <= s1_tuser;
        s2_tlast <= s1_tlast;
        s3_data  <= pix;
        s3_tuser <= s2_tuser;
        s3_tlast <= s2_tlast;
    end

    // Headroom of 4 entries absorbs the three beats already in the pipeline.
    assign almost_full   = fifo_count >= AF_LEVEL;
    assign s_axis_tready = !almost_full || !resetn;
    assign fifo_rd       = (!m_axis_tvalid || m_axis_tready) && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (s3_valid) mem[wr_ptr] <= {s3_tuser, s3_tlast, s3_data};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (s3_valid) wr_ptr <= wr_ptr + C_FIFO_AW'(1);
            if (fifo_rd)  rd_ptr <= rd_ptr + C_FIFO_AW'(1);
            case ({s3_valid, fifo_rd})
                2'b10:   fifo_count <= fifo_count + (C_FIFO_AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (C_FIFO_AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (fifo_rd) begin
                m_axis_tvalid <= 1'b1;
                {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
